imm_extend_arbiter: RTL and testbench



---
 rtl/imm_extend_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_imm_extend_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imm_extend_arbiter.sv
// imm_extend_arbiter: shares one byte-to-word extension unit between the
// decode immediate path (req0) and the load-byte path (req1).
// Ports: clk, reset (sync, active-high); reqN_valid/byte/mode in, reqN_ready
// out; out_valid/out_data/out_tag out with out_ready in; busy, err_timeout.
// Optional macro HOLD_TIMEOUT_EN adds a HOLD_HI watchdog of TIMEOUT cycles.
module imm_extend_arbiter #(
    parameter int IN_W    = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [IN_W-1:0]   req0_byte,
    input  logic [1:0]        req0_mode,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [IN_W-1:0]   req1_byte,
    input  logic [1:0]        req1_mode,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [2*IN_W-1:0] out_data,
    output logic              out_tag,
    input  logic              out_ready,
    output logic              busy,
    output logic              err_timeout
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [1:0] M_HI   = 2'b10;
    localparam logic [1:0] M_SEXT = 2'b01;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   hi_q, hi_d;
    logic              lock_q, lock_d;
    logic              rr_q, rr_d;
    logic              out_valid_q, out_valid_d;
    logic [2*IN_W-1:0] out_data_q, out_data_d;
    logic              out_tag_q, out_tag_d;
    logic              busy_q, busy_d;

    logic              slot_free;
    logic              have_cand;
    logic              cand;
    logic              cand_valid;
    logic [IN_W-1:0]   cand_byte;
    logic [1:0]        cand_mode;
    logic              cand_hi;
    logic              cand_rdy;
    logic              accept;
    logic              load;
    logic              abort;

    assign slot_free = !out_valid_q || out_ready;

    // HOLD_HI locks the grant; otherwise the rr pointer breaks ties.
    always_comb begin
        have_cand = 1'b0;
        cand      = 1'b0;
        if (state_q == S_HOLD) begin
            have_cand = 1'b1;
            cand      = lock_q;
        end else if (req0_valid && req1_valid) begin
            have_cand = 1'b1;
            cand      = rr_q;
        end else if (req0_valid) begin
            have_cand = 1'b1;
            cand      = 1'b0;
        end else if (req1_valid) begin
            have_cand = 1'b1;
            cand      = 1'b1;
        end
    end

    assign cand_valid = cand ? req1_valid : req0_valid;
    assign cand_byte  = cand ? req1_byte  : req0_byte;
    assign cand_mode  = cand ? req1_mode  : req0_mode;
    assign cand_hi    = (cand_mode == M_HI);

    // A high-byte capture never touches the output slot, so it
    // does not wait for the slot to drain.
    assign cand_rdy   = have_cand && (cand_hi || slot_free);
    assign req0_ready = cand_rdy && !cand;
    assign req1_ready = cand_rdy && cand;
    assign accept     = cand_rdy && cand_valid;
    assign load       = accept && !cand_hi;

`ifdef HOLD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q;

    // Counter sits at zero outside HOLD_HI, so entry starts from zero.
    always_comb begin
        cnt_d = '0;
        abort = 1'b0;
        if (state_q == S_HOLD && !accept) begin
            if (cnt_q == CW'(TIMEOUT - 1)) begin
                abort = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign err_timeout = err_q;
`else
    assign abort       = 1'b0;
    assign err_timeout = 1'b0;

    // TIMEOUT only matters when the hold watchdog is compiled in.
    if (TIMEOUT < 1) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lock_d      = lock_q;
        rr_d        = rr_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        if (accept && cand_hi) begin
            hi_d    = cand_byte;
            lock_d  = cand;
            state_d = S_HOLD;
        end else if (load) begin
            out_valid_d = 1'b1;
            out_tag_d   = cand;
            rr_d        = !cand;
            state_d     = S_IDLE;
            if (state_q == S_HOLD) begin
                out_data_d = {hi_q, cand_byte};
            end else if (cand_mode == M_SEXT) begin
                out_data_d = {{IN_W{cand_byte[IN_W-1]}}, cand_byte};
            end else begin
                out_data_d = {{IN_W{1'b0}}, cand_byte};
            end
        end else if (abort) begin
            state_d = S_IDLE;
            hi_d    = '0;
            rr_d    = !lock_q;
        end
        busy_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            hi_q        <= '0;
            lock_q      <= 1'b0;
            rr_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef HOLD_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lock_q      <= lock_d;
            rr_q        <= rr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            busy_q      <= busy_d;
`ifdef HOLD_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= abort;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_imm_extend_arbiter.sv
// tb_imm_extend_arbiter: directed plus random stimulus against a
// rule-level model; results are checked through a scoreboard queue.
module tb_imm_extend_arbiter;

    localparam int W  = 8;
    localparam int TO = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           req0_valid = 1'b0;
    logic [W-1:0]   req0_byte = '0;
    logic [1:0]     req0_mode = '0;
    logic           req0_ready;
    logic           req1_valid = 1'b0;
    logic [W-1:0]   req1_byte = '0;
    logic [1:0]     req1_mode = '0;
    logic           req1_ready;
    logic           out_valid;
    logic [2*W-1:0] out_data;
    logic           out_tag;
    logic           out_ready = 1'b0;
    logic           busy;
    logic           err_timeout;

    always #5 clk = ~clk;

    imm_extend_arbiter #(.IN_W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_byte  (req0_byte),
        .req0_mode  (req0_mode),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_byte  (req1_byte),
        .req1_mode  (req1_mode),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_tag    (out_tag),
        .out_ready  (out_ready),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        t;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model state: what the arbiter should look like in the current cycle.
    bit       m_hold, m_lock, m_fav, m_ov, m_err, m_after;
    int       m_hi, m_cnt;
    bit       pv[2];
    int       pb[2];
    int       pm[2];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int extend(int b, int mode);
        if (mode == 1 && b >= 128) return b + 'hFF00;
        return b;
    endfunction

    // Predictor: checks handshake signals and pushes expected results.
    always @(negedge clk) begin
        bit sf, have, c, acc;
        res_t r;
        #1;
        if (reset) begin
            m_hold = 0; m_lock = 0; m_fav = 0; m_ov = 0; m_err = 0;
            m_hi = 0; m_cnt = 0; m_after = 1;
            exp_q.delete();
        end else begin
            pv[0] = req0_valid; pb[0] = int'(req0_byte); pm[0] = int'(req0_mode);
            pv[1] = req1_valid; pb[1] = int'(req1_byte); pm[1] = int'(req1_mode);
            if (m_after) begin
                chk("rst_data", out_data, 0);
                chk("rst_tag", out_tag, 0);
                m_after = 0;
            end
            chk("out_valid", out_valid, m_ov);
            chk("busy", busy, m_hold);
            chk("err_timeout", err_timeout, m_err);
            sf = !m_ov || out_ready;
            have = 0; c = 0;
            if (m_hold) begin have = 1; c = m_lock; end
            else if (pv[0] && pv[1]) begin have = 1; c = m_fav; end
            else if (pv[0]) begin have = 1; c = 0; end
            else if (pv[1]) begin have = 1; c = 1; end
            chk("req0_ready", req0_ready, have && !c && (pm[0] == 2 || sf));
            chk("req1_ready", req1_ready, have && c && (pm[1] == 2 || sf));
            acc = have && pv[c] && (pm[c] == 2 || sf);
            m_err = 0;
            if (acc && pm[c] == 2) begin
                if (out_ready) m_ov = 0;
                m_hi = pb[c]; m_lock = c; m_hold = 1; m_cnt = 0;
            end else if (acc) begin
                r.t = c;
                r.d = m_hold ? 16'(m_hi * 256 + pb[c]) : 16'(extend(pb[c], pm[c]));
                exp_q.push_back(r);
                m_ov = 1; m_hold = 0; m_fav = !c; m_cnt = 0;
            end else begin
                if (out_ready) m_ov = 0;
`ifdef HOLD_TIMEOUT_EN
                if (m_hold) begin
                    m_cnt++;
                    if (m_cnt == TO) begin
                        m_hold = 0; m_hi = 0; m_fav = !m_lock; m_err = 1; m_cnt = 0;
                    end
                end
`endif
            end
        end
    end

    // Monitor: pops one expected result per output handshake.
    always @(negedge clk) begin
        res_t r;
        #2;
        if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h tag %0d expected none", out_data, out_tag);
            end else begin
                r = exp_q.pop_front();
                chk("out_data", out_data, r.d);
                chk("out_tag", out_tag, r.t);
            end
        end
    end

    task automatic drv(bit v0, logic [7:0] b0, logic [1:0] m0,
                       bit v1, logic [7:0] b1, logic [1:0] m1, bit ordy);
        @(negedge clk);
        req0_valid = v0; req0_byte = b0; req0_mode = m0;
        req1_valid = v1; req1_byte = b1; req1_mode = m1;
        out_ready = ordy;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        // Basic extensions
        drv(1, 8'hF0, 2'b00, 0, 8'h00, 2'b00, 1);
        drv(0, 8'h00, 2'b00, 1, 8'h85, 2'b01, 1);
        drv(0, 8'h00, 2'b00, 1, 8'h85, 2'b11, 1);
        // Both valid: alternating grants
        for (int i = 0; i < 4; i++)
            drv(1, 8'(i), 2'b00, 1, 8'(i + 16), 2'b00, 1);
        // High capture then pair, req1 waiting
        drv(1, 8'h12, 2'b10, 1, 8'h55, 2'b00, 1);
        drv(1, 8'h34, 2'b00, 1, 8'h56, 2'b00, 1);
        drv(1, 8'h77, 2'b00, 1, 8'h66, 2'b00, 1);
        // Backpressure
        drv(1, 8'hAA, 2'b00, 0, 8'h00, 2'b00, 0);
        for (int i = 0; i < 3; i++)
            drv(1, 8'hBB, 2'b00, 0, 8'h00, 2'b00, 0);
        drv(1, 8'hBB, 2'b00, 0, 8'h00, 2'b00, 1);
        drv(0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 1);
        // Reset while holding with an output pending
        drv(1, 8'h55, 2'b00, 0, 8'h00, 2'b00, 0);
        drv(1, 8'h12, 2'b10, 0, 8'h00, 2'b00, 0);
        drv(0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 0);
        reset = 1'b1;
        drv(0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 1);
        reset = 1'b0;
        drv(0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 1);
        // Locked requester goes quiet
        drv(1, 8'h12, 2'b10, 0, 8'h00, 2'b00, 1);
        for (int i = 0; i < 5; i++)
            drv(0, 8'h00, 2'b00, 1, 8'h99, 2'b00, 1);
        drv(1, 8'h34, 2'b00, 0, 8'h00, 2'b00, 1);
        // Random traffic
        for (int i = 0; i < 400; i++)
            drv(1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 8'($urandom), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) != 0));
        // Drain
        repeat (3) drv(0, 8'h00, 2'b00, 0, 8'h00, 2'b00, 1);
        @(negedge clk);
        #3;
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
